axi_lite_reg_slave: RTL and testbench

//  AXI4-Lite slave endpoint; consumes the SLAVE modport of axi_lite_if.

---
 rtl/axi_lite_pkg.sv | 20 ++
 rtl/axi_lite_if.sv | 43 ++++
 rtl/axi_lite_reg_slave.sv | 169 ++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, response codes and the byte-lane merge helper
// used by the register slave and its bus interface.
package axi_lite_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic word_t wstrb_merge(word_t old, word_t wdata, logic [3:0] wstrb);
    word_t merged;
    merged = old;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle (AW, W, B, AR, R) with master and slave views.
interface axi_lite_if;
  import axi_lite_pkg::*;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;

  word_t       wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;

  word_t       rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register slave: RW control bank plus RO status words in one 4 KiB window.
// Define AXIL_SLVERR_EN to answer misses and writes to status words with SLVERR.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          NUM_CTRL  = 8,
  parameter int          NUM_STAT  = 4,
  parameter word_t       CTRL_RST  = 32'h0
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  axi_lite_if.slave           s_axi,
  output word_t               ctrl_o [NUM_CTRL],
  output logic [NUM_CTRL-1:0] ctrl_wr_pulse,
  input  word_t               stat_i [NUM_STAT]
);

  localparam int NUM_REGS = NUM_CTRL + NUM_STAT;

  typedef enum logic [1:0] {DEC_CTRL, DEC_STAT, DEC_MISS} dec_e;

  // Classify a word address (byte address bits [31:2]) within the window.
  function automatic dec_e decode(logic [29:0] word_addr);
    if (word_addr[29:10] != BASE_ADDR[31:12]) return DEC_MISS;
    if (int'(word_addr[9:0]) < NUM_CTRL)      return DEC_CTRL;
    if (int'(word_addr[9:0]) < NUM_REGS)      return DEC_STAT;
    return DEC_MISS;
  endfunction

  logic        rdy_en;
  word_t       ctrl_q [NUM_CTRL];

  logic        aw_held, w_held;
  logic [29:0] aw_addr_q;
  word_t       w_data_q;
  logic [3:0]  w_strb_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;

  logic        aw_hs, w_hs, commit;
  logic [29:0] wr_addr;
  word_t       wr_data;
  logic [3:0]  wr_strb;
  dec_e        wr_dec;
  logic [1:0]  wr_resp;

  logic        ar_hs;
  dec_e        rd_dec;
  word_t       rd_data;
  logic [1:0]  rd_resp;
  logic        rvalid_q;
  word_t       rdata_q;
  logic [1:0]  rresp_q;

  // READYs stay low until the first edge after reset release.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  assign s_axi.awready = rdy_en & ~aw_held & ~bvalid_q;
  assign s_axi.wready  = rdy_en & ~w_held  & ~bvalid_q;
  assign s_axi.arready = rdy_en & ~rvalid_q;

  assign aw_hs  = s_axi.awvalid & s_axi.awready;
  assign w_hs   = s_axi.wvalid  & s_axi.wready;
  assign commit = (aw_held | aw_hs) & (w_held | w_hs);

  assign wr_addr = aw_held ? aw_addr_q : s_axi.awaddr[31:2];
  assign wr_data = w_held  ? w_data_q  : s_axi.wdata;
  assign wr_strb = w_held  ? w_strb_q  : s_axi.wstrb;
  assign wr_dec  = decode(wr_addr);

`ifdef AXIL_SLVERR_EN
  assign wr_resp = (wr_dec == DEC_CTRL) ? RESP_OKAY : RESP_SLVERR;
`else
  assign wr_resp = RESP_OKAY;
`endif

  // Write channel: park whichever of AW/W arrives first, commit once both are present.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else if (commit) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b1;
      bresp_q  <= wr_resp;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi.awaddr[31:2];
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi.wdata;
        w_strb_q <= s_axi.wstrb;
      end
      if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;
    end
  end

  assign s_axi.bvalid = bvalid_q;
  assign s_axi.bresp  = bresp_q;

  // NOTE: the control bank is a small register file feeding analog controls, so every entry is reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= CTRL_RST;
      ctrl_wr_pulse <= '0;
    end else begin
      ctrl_wr_pulse <= '0;
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (commit && wr_dec == DEC_CTRL && int'(wr_addr[9:0]) == i) begin
          ctrl_q[i]        <= wstrb_merge(ctrl_q[i], wr_data, wr_strb);
          ctrl_wr_pulse[i] <= 1'b1;
        end
      end
    end
  end

  assign ctrl_o = ctrl_q;

  assign ar_hs  = s_axi.arvalid & s_axi.arready;
  assign rd_dec = decode(s_axi.araddr[31:2]);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (rd_dec == DEC_CTRL && int'(s_axi.araddr[11:2]) == i) rd_data = ctrl_q[i];
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      if (rd_dec == DEC_STAT && int'(s_axi.araddr[11:2]) == NUM_CTRL + j) rd_data = stat_i[j];
    end
`ifdef AXIL_SLVERR_EN
    if (rd_dec == DEC_MISS) rd_resp = RESP_SLVERR;
`endif
  end

  // Read data is captured at the AR handshake and held until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axi.rvalid = rvalid_q;
  assign s_axi.rdata  = rdata_q;
  assign s_axi.rresp  = rresp_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Scoreboard bench for axi_lite_reg_slave: directed scenarios followed by random traffic,
// checked against an address-map model of the register window.
`timescale 1ns/1ps
module tb_axi_lite_reg_slave;
  import axi_lite_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          NC   = 8;
  localparam int          NS   = 4;
  localparam word_t       CRST = 32'h0;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  axi_lite_if bus ();
  word_t          ctrl_o [NC];
  logic [NC-1:0]  ctrl_wr_pulse;
  word_t          stat_i [NS];

  axi_lite_reg_slave #(
    .BASE_ADDR(BASE), .NUM_CTRL(NC), .NUM_STAT(NS), .CTRL_RST(CRST)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(bus.slave),
    .ctrl_o(ctrl_o), .ctrl_wr_pulse(ctrl_wr_pulse), .stat_i(stat_i)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired, required a handshake", name);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]         resp;
    logic [NC-1:0]      pulse;
    logic [NC*32-1:0]   img;
  } b_exp_t;

  typedef struct packed {
    logic [1:0] resp;
    word_t      data;
  } r_exp_t;

  word_t  model_ctrl [NC];
  b_exp_t b_q [$];
  r_exp_t r_q [$];

  // Register number addressed, or -1 when the address is outside the map.
  function automatic int reg_index(logic [31:0] addr);
    int idx;
    if ((addr & 32'hFFFF_F000) != BASE) return -1;
    idx = int'((addr & 32'h0000_0FFF) / 4);
    if (idx >= NC + NS) return -1;
    return idx;
  endfunction

  function automatic b_exp_t model_write(logic [31:0] addr, word_t data, logic [3:0] strb);
    b_exp_t e;
    int r;
    r = reg_index(addr);
    e.resp  = 2'b00;
    e.pulse = '0;
    e.img   = '0;
    if (r >= 0 && r < NC) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_ctrl[r][8*b +: 8] = data[8*b +: 8];
      e.pulse[r] = 1'b1;
    end else begin
`ifdef AXIL_SLVERR_EN
      e.resp = 2'b10;
`endif
    end
    for (int i = 0; i < NC; i++) e.img[i*32 +: 32] = model_ctrl[i];
    return e;
  endfunction

  function automatic r_exp_t model_read(logic [31:0] addr);
    r_exp_t e;
    int r;
    r = reg_index(addr);
    e.resp = 2'b00;
    e.data = 32'h0;
    if (r < 0) begin
`ifdef AXIL_SLVERR_EN
      e.resp = 2'b10;
`endif
    end else if (r < NC) e.data = model_ctrl[r];
    else                 e.data = stat_i[r - NC];
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic   bv_prev;
    logic   r_wait;
    word_t  rd_hold;
    b_exp_t be;
    r_exp_t re;
    bv_prev = 1'b0;
    r_wait  = 1'b0;
    rd_hold = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        bv_prev = 1'b0;
        r_wait  = 1'b0;
      end else begin
        if (bus.bvalid && !bv_prev) begin
          if (b_q.size() == 0) timeout("bvalid_without_write");
          else begin
            be = b_q[0];
            check("wr_pulse", ctrl_wr_pulse, be.pulse);
            for (int i = 0; i < NC; i++)
              check($sformatf("ctrl_o[%0d]", i), ctrl_o[i], be.img[i*32 +: 32]);
          end
        end else if (ctrl_wr_pulse != '0) begin
          check("stray_pulse", ctrl_wr_pulse, '0);
        end
        if (bus.bvalid && bus.bready) begin
          if (b_q.size() == 0) timeout("b_handshake_without_write");
          else begin
            be = b_q.pop_front();
            check("bresp", bus.bresp, be.resp);
          end
        end
        if (r_wait) begin
          check("rvalid_hold", bus.rvalid, 1'b1);
          check("rdata_stable", bus.rdata, rd_hold);
        end
        if (bus.rvalid && bus.rready) begin
          if (r_q.size() == 0) timeout("r_handshake_without_read");
          else begin
            re = r_q.pop_front();
            check("rdata", bus.rdata, re.data);
            check("rresp", bus.rresp, re.resp);
          end
        end
        bv_prev = bus.bvalid;
        r_wait  = bus.rvalid && !bus.rready;
        rd_hold = bus.rdata;
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_aw(input logic [31:0] addr, input int dly);
    int n;
    n = 0;
    repeat (dly) @(posedge ACLK);
    #1;
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    @(negedge ACLK);
    while (!bus.awready && n < 50) begin @(negedge ACLK); n++; end
    if (!bus.awready) timeout("aw_wait");
    @(posedge ACLK);
    #1 bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input word_t data, input logic [3:0] strb, input int dly);
    int n;
    n = 0;
    repeat (dly) @(posedge ACLK);
    #1;
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.wvalid = 1'b1;
    @(negedge ACLK);
    while (!bus.wready && n < 50) begin @(negedge ACLK); n++; end
    if (!bus.wready) timeout("w_wait");
    @(posedge ACLK);
    #1 bus.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr, input int dly);
    int n;
    n = 0;
    repeat (dly) @(posedge ACLK);
    #1;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    @(negedge ACLK);
    while (!bus.arready && n < 50) begin @(negedge ACLK); n++; end
    if (!bus.arready) timeout("ar_wait");
    @(posedge ACLK);
    #1 bus.arvalid = 1'b0;
  endtask

  task automatic finish_b(input int dly);
    int n;
    n = 0;
    while (!bus.bvalid && n < 50) begin @(negedge ACLK); n++; end
    if (!bus.bvalid) begin timeout("b_wait"); return; end
    @(posedge ACLK);
    repeat (dly) @(posedge ACLK);
    #1 bus.bready = 1'b1;
    @(posedge ACLK);
    #1 bus.bready = 1'b0;
  endtask

  task automatic read_tail(input int dly);
    int n;
    n = 0;
    @(negedge ACLK);
    check("rvalid_latency", bus.rvalid, 1'b1);
    while (!bus.rvalid && n < 50) begin @(negedge ACLK); n++; end
    if (!bus.rvalid) begin timeout("r_wait"); return; end
    @(posedge ACLK);
    repeat (dly) @(posedge ACLK);
    #1 bus.rready = 1'b1;
    @(posedge ACLK);
    #1 bus.rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input word_t data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    b_q.push_back(model_write(addr, data, strb));
    fork
      send_aw(addr, aw_dly);
      send_w(data, strb, w_dly);
    join
    @(negedge ACLK);
    check("bvalid_latency", bus.bvalid, 1'b1);
    finish_b(b_dly);
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
    r_q.push_back(model_read(addr));
    send_ar(addr, ar_dly);
    read_tail(r_dly);
  endtask

  function automatic logic [31:0] gen_addr();
    int kind;
    kind = $urandom_range(0, 9);
    if (kind <= 5) return BASE + 32'($urandom_range(0, NC - 1) * 4) + 32'($urandom_range(0, 3));
    if (kind <= 7) return BASE + 32'($urandom_range(NC, NC + NS - 1) * 4);
    if (kind == 8) return BASE + 32'($urandom_range(NC + NS, 1023) * 4);
    return (BASE ^ (32'h1 << $urandom_range(12, 31))) + 32'($urandom_range(0, 4095));
  endfunction

  task automatic check_readys(input string tag, input logic exp);
    check({tag, "_awready"}, bus.awready, exp);
    check({tag, "_wready"},  bus.wready,  exp);
    check({tag, "_arready"}, bus.arready, exp);
  endtask

  // ---------------- main sequence ----------------
  initial begin : stimulus
    word_t  w;
    r_exp_t rx;
    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb   = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    for (int i = 0; i < NS; i++) stat_i[i] = $urandom;
    for (int i = 0; i < NC; i++) model_ctrl[i] = CRST;

    // Reset state
    #3;
    check_readys("reset", 1'b0);
    check("reset_bvalid", bus.bvalid, 1'b0);
    check("reset_rvalid", bus.rvalid, 1'b0);
    check("reset_pulse", ctrl_wr_pulse, '0);
    for (int i = 0; i < NC; i++) check($sformatf("reset_ctrl[%0d]", i), ctrl_o[i], CRST);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    #1 check_readys("release", 1'b0);
    @(posedge ACLK);
    #1 check_readys("ready_up", 1'b1);

    // 1: AW and W together
    do_write(32'h4000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    check("t1_ctrl1", ctrl_o[1], 32'hDEAD_BEEF);

    // 2: W three cycles ahead of AW, partial strobe
    fork
      send_w(32'h1122_3344, 4'h5, 0);
      send_aw(32'h4000_0000, 3);
      begin
        @(posedge ACLK);
        repeat (3) begin @(negedge ACLK); check("t2_wready_low", bus.wready, 1'b0); end
      end
    join
    b_q.push_back(model_write(32'h4000_0000, 32'h1122_3344, 4'h5));
    @(negedge ACLK);
    check("t2_bvalid", bus.bvalid, 1'b1);
    finish_b(1);
    check("t2_ctrl0", ctrl_o[0], 32'h0022_0044);

    // 3: status read with RREADY held off
    stat_i[0] = 32'hA5A5_0001;
    do_read(32'h4000_0020, 0, 5);

    // 4: read miss and write to a status word
    do_read(32'h4000_0FFC, 0, 0);
    do_write(32'h4000_0024, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);

    // 5: read of index 2 racing its own commit
    do_write(32'h4000_0008, 32'h1234_5678, 4'hF, 0, 1, 0);
    r_q.push_back(model_read(32'h4000_0008));
    fork
      do_write(32'h4000_0008, 32'h0000_0055, 4'hF, 0, 0, 1);
      begin send_ar(32'h4000_0008, 0); read_tail(2); end
    join
    rx = model_read(32'h4000_0008);
    check("t5_model_new", rx.data, 32'h0000_0055);
    do_read(32'h4000_0008, 0, 0);

    // 6: reset between AW and W
    send_aw(32'h4000_000C, 0);
    #2 ARESETN = 1'b0;
    for (int i = 0; i < NC; i++) model_ctrl[i] = CRST;
    #1;
    check_readys("midrst", 1'b0);
    check("midrst_bvalid", bus.bvalid, 1'b0);
    check("midrst_rvalid", bus.rvalid, 1'b0);
    for (int i = 0; i < NC; i++) check($sformatf("midrst_ctrl[%0d]", i), ctrl_o[i], CRST);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    #1 check_readys("rerelease", 1'b0);
    @(posedge ACLK);
    #1 check_readys("reready", 1'b1);
    do_write(32'h4000_0010, 32'hCAFE_F00D, 4'hF, 2, 0, 0);
    do_read(32'h4000_000C, 0, 0);

    // WSTRB = 0: pulse, no data change
    do_write(32'h4000_0010, 32'h0BAD_0BAD, 4'h0, 0, 0, 0);

    // Random traffic
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        w = $urandom;
        do_write(gen_addr(), w, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end else begin
        for (int i = 0; i < NS; i++) stat_i[i] = $urandom;
        do_read(gen_addr(), $urandom_range(0, 2), $urandom_range(0, 3));
      end
    end

    repeat (4) @(negedge ACLK);
    check("b_queue_empty", b_q.size(), 0);
    check("r_queue_empty", r_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
